// File: rtl/tomasulo_core_if.sv
// Fetch, instruction-memory programming and commit signals of tomasulo_core.
interface tomasulo_core_if #(
  parameter int DATA_W = 16
);
  logic              [3:0] pc;
  logic                    imem_we;
  logic              [3:0] imem_addr;
  logic             [15:0] imem_data;
  logic                    stall;
  logic                    commit_valid;
  logic              [3:0] commit_reg;
  logic       [DATA_W-1:0] commit_value;

  modport master (
    output pc, imem_we, imem_addr, imem_data,
    input  stall, commit_valid, commit_reg, commit_value
  );

  modport slave (
    input  pc, imem_we, imem_addr, imem_data,
    output stall, commit_valid, commit_reg, commit_value
  );
endinterface

// File: rtl/tomasulo_core.sv
// Single-issue Tomasulo core: 8-entry ROB, 3 add + 3 mul reservation stations,
// one non-pipelined adder and multiplier sharing one CDB, in-order commit.
module tomasulo_core #(
  parameter int DATA_W  = 16,
  parameter int ADD_LAT = 2,
  parameter int MUL_LAT = 4
) (
  input  logic           clk1,
  input  logic           rst,
  tomasulo_core_if.slave bus
);
  localparam int NRS = 3;  // stations per unit: add at 0..2, mul at 3..5
  typedef logic [DATA_W-1:0] word_t;

  logic [15:0] imem [16];
  word_t       regbank [16];
  logic [3:0]  status [16];

  logic        rob_busy [8];
  logic        rob_ready [8];
  logic [3:0]  rob_dest [8];
  word_t       rob_value [8];
  logic [2:0]  head, tail;
  logic [3:0]  count;

  logic        rs_busy [2*NRS];
  logic        rs_sub [2*NRS];
  word_t       rs_vj [2*NRS];
  word_t       rs_vk [2*NRS];
  logic [3:0]  rs_qj [2*NRS];
  logic [3:0]  rs_qk [2*NRS];
  logic [3:0]  rs_tag [2*NRS];

  logic        fu_busy [2];
  logic [2:0]  fu_cnt [2];
  logic [3:0]  fu_tag [2];
  word_t       fu_res [2];
  logic [1:0]  fu_done, fu_grant;
  logic [1:0]  free_ok, rdy_ok;
  logic [2:0]  free_idx [2];
  logic [2:0]  rdy_idx [2];

  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [2:0]  cdb_idx;
  word_t       cdb_value;

  logic [15:0] instr;
  logic [3:0]  opc, rd;
  logic [3:0]  src [2];
  logic [3:0]  st_tag [2];
  logic [2:0]  st_idx [2];
  word_t       op_val [2];
  logic [3:0]  op_q [2];
  logic        is_add, is_mul, stall, do_issue, do_commit;
  logic [2:0]  issue_rs;
  logic [3:0]  new_tag, head_tag;

  assign instr  = imem[bus.pc];
  assign opc    = instr[15:12];
  assign rd     = instr[11:8];
  assign src[0] = instr[7:4];
  assign src[1] = instr[3:0];
  assign is_add = (opc == 4'd1) || (opc == 4'd2);
  assign is_mul = (opc == 4'd3);

  for (genvar gi = 0; gi < 2; gi++) begin : g_fu
    assign fu_done[gi] = fu_busy[gi] && (fu_cnt[gi] == 3'd0);
  end

  // Multiplier owns the CDB on a tie; the adder keeps its result for a later edge.
  assign fu_grant[1] = fu_done[1];
  assign fu_grant[0] = fu_done[0] && !fu_done[1];
  assign cdb_valid   = fu_done[0] || fu_done[1];
  assign cdb_tag     = fu_done[1] ? fu_tag[1] : fu_tag[0];
  assign cdb_value   = fu_done[1] ? fu_res[1] : fu_res[0];
  assign cdb_idx     = 3'(cdb_tag - 4'd1);

  always_comb begin
    for (int u = 0; u < 2; u++) begin
      free_ok[u]  = 1'b0;
      free_idx[u] = '0;
      rdy_ok[u]   = 1'b0;
      rdy_idx[u]  = '0;
      for (int i = NRS - 1; i >= 0; i--) begin
        if (!rs_busy[u*NRS+i]) begin
          free_ok[u]  = 1'b1;
          free_idx[u] = 3'(u*NRS+i);
        end
        if (rs_busy[u*NRS+i] && rs_qj[u*NRS+i] == 4'd0 && rs_qk[u*NRS+i] == 4'd0) begin
          rdy_ok[u]  = 1'b1;
          rdy_idx[u] = 3'(u*NRS+i);
        end
      end
    end
  end

  // Operand source priority: register bank, finished ROB entry, same-edge CDB, else wait on tag.
  for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
    assign st_tag[gi] = status[src[gi]];
    assign st_idx[gi] = 3'(st_tag[gi] - 4'd1);
    always_comb begin
      op_val[gi] = '0;
      op_q[gi]   = 4'd0;
      if (st_tag[gi] == 4'd0)
        op_val[gi] = regbank[src[gi]];
      else if (rob_ready[st_idx[gi]])
        op_val[gi] = rob_value[st_idx[gi]];
      else if (cdb_valid && cdb_tag == st_tag[gi])
        op_val[gi] = cdb_value;
      else
        op_q[gi] = st_tag[gi];
    end
  end

  assign stall     = (is_add && (!free_ok[0] || count == 4'd8)) ||
                     (is_mul && (!free_ok[1] || count == 4'd8));
  assign bus.stall = stall;
  assign do_issue  = (is_add || is_mul) && !stall;
  assign issue_rs  = is_mul ? free_idx[1] : free_idx[0];
  assign new_tag   = {1'b0, tail} + 4'd1;
  assign head_tag  = {1'b0, head} + 4'd1;
  assign do_commit = rob_busy[head] && rob_ready[head];

  always_ff @(posedge clk1) begin
    if (bus.imem_we)
      imem[bus.imem_addr] <= bus.imem_data;
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 16; k++) begin
        regbank[k] <= word_t'(k);
        status[k]  <= '0;
      end
      for (int k = 0; k < 8; k++) begin
        rob_busy[k]  <= 1'b0;
        rob_ready[k] <= 1'b0;
        rob_dest[k]  <= '0;
        rob_value[k] <= '0;
      end
      for (int k = 0; k < 2*NRS; k++) begin
        rs_busy[k] <= 1'b0;
        rs_sub[k]  <= 1'b0;
        rs_vj[k]   <= '0;
        rs_vk[k]   <= '0;
        rs_qj[k]   <= '0;
        rs_qk[k]   <= '0;
        rs_tag[k]  <= '0;
      end
      for (int u = 0; u < 2; u++) begin
        fu_busy[u] <= 1'b0;
        fu_cnt[u]  <= '0;
        fu_tag[u]  <= '0;
        fu_res[u]  <= '0;
      end
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      bus.commit_valid <= 1'b0;
      bus.commit_reg   <= '0;
      bus.commit_value <= '0;
    end else begin
      if (cdb_valid) begin
        rob_value[cdb_idx] <= cdb_value;
        rob_ready[cdb_idx] <= 1'b1;
        for (int i = 0; i < 2*NRS; i++) begin
          if (rs_busy[i] && rs_qj[i] == cdb_tag) begin
            rs_qj[i] <= '0;
            rs_vj[i] <= cdb_value;
          end
          if (rs_busy[i] && rs_qk[i] == cdb_tag) begin
            rs_qk[i] <= '0;
            rs_vk[i] <= cdb_value;
          end
        end
      end

      for (int u = 0; u < 2; u++) begin
        if (fu_busy[u]) begin
          if (fu_cnt[u] != 3'd0)
            fu_cnt[u] <= fu_cnt[u] - 3'd1;
          else if (fu_grant[u])
            fu_busy[u] <= 1'b0;
        end else if (rdy_ok[u]) begin
          fu_busy[u]          <= 1'b1;
          fu_tag[u]           <= rs_tag[rdy_idx[u]];
          rs_busy[rdy_idx[u]] <= 1'b0;
          if (u == 0) begin
            fu_cnt[u] <= 3'(ADD_LAT - 1);
            fu_res[u] <= rs_sub[rdy_idx[u]] ? rs_vj[rdy_idx[u]] - rs_vk[rdy_idx[u]]
                                            : rs_vj[rdy_idx[u]] + rs_vk[rdy_idx[u]];
          end else begin
            fu_cnt[u] <= 3'(MUL_LAT - 1);
            fu_res[u] <= rs_vj[rdy_idx[u]] * rs_vk[rdy_idx[u]];
          end
        end
      end

      bus.commit_valid <= do_commit;
      if (do_commit) begin
        regbank[rob_dest[head]] <= rob_value[head];
        rob_busy[head]          <= 1'b0;
        rob_ready[head]         <= 1'b0;
        if (status[rob_dest[head]] == head_tag)
          status[rob_dest[head]] <= '0;
        head             <= head + 3'd1;
        bus.commit_reg   <= rob_dest[head];
        bus.commit_value <= rob_value[head];
      end

      // Issue is applied after commit so a newer rename of the same register wins.
      if (do_issue) begin
        rob_busy[tail]    <= 1'b1;
        rob_ready[tail]   <= 1'b0;
        rob_dest[tail]    <= rd;
        status[rd]        <= new_tag;
        tail              <= tail + 3'd1;
        rs_busy[issue_rs] <= 1'b1;
        rs_sub[issue_rs]  <= (opc == 4'd2);
        rs_vj[issue_rs]   <= op_val[0];
        rs_qj[issue_rs]   <= op_q[0];
        rs_vk[issue_rs]   <= op_val[1];
        rs_qk[issue_rs]   <= op_q[1];
        rs_tag[issue_rs]  <= new_tag;
      end

      count <= count + {3'b000, do_issue} - {3'b000, do_commit};
    end
  end
endmodule

// File: tb/tb_tomasulo_core.sv
// Random and directed programs checked against an in-order architectural model of the core.
module tb_tomasulo_core;
  logic clk1 = 1'b0;
  logic rst  = 1'b1;

  tomasulo_core_if #(.DATA_W(16)) bus ();

  tomasulo_core #(.DATA_W(16), .ADD_LAT(2), .MUL_LAT(4)) dut (
    .clk1 (clk1),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 clk1 = ~clk1;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] prog [15];
  int          prog_len = 0;
  logic [15:0] ref_reg [16];
  logic [19:0] exp_q [$];
  int          edge_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic reset_model();
    for (int k = 0; k < 16; k++) ref_reg[k] = 16'(k);
    exp_q.delete();
    edge_q.delete();
  endtask

  function automatic logic [15:0] enc(input int op, input int rd, input int a, input int b);
    return {4'(op), 4'(rd), 4'(a), 4'(b)};
  endfunction

  task automatic load_prog(input int n);
    bus.pc   = 4'd15;
    prog_len = n;
    for (int i = 0; i < n; i++) begin
      @(negedge clk1);
      bus.imem_we   = 1'b1;
      bus.imem_addr = 4'(i);
      bus.imem_data = prog[i];
    end
    @(negedge clk1);
    bus.imem_we = 1'b0;
  endtask

  // Drives pc through the program, holding it while stalled; every op that issues
  // is executed in program order on ref_reg and its result queued for commit.
  task automatic run_prog(input string name, input bit expect_stall);
    int          idx = 0;
    int          ecount = 0;
    int          budget = 400;
    bit          saw = 1'b0;
    bit          first_seen = 1'b0;
    bit          first_checked = 1'b0;
    int          first_lat = 0;
    int          ie;
    logic        st;
    logic [15:0] w, a, b, v;
    logic [3:0]  op;
    logic [19:0] e;
    exp_q.delete();
    edge_q.delete();
    while ((idx < prog_len || exp_q.size() != 0) && budget > 0) begin
      budget--;
      @(negedge clk1);
      bus.pc = (idx < prog_len) ? 4'(idx) : 4'd15;
      #1 st = bus.stall;
      if (st === 1'b1) saw = 1'b1;
      @(posedge clk1);
      ecount++;
      if (st === 1'b0 && idx < prog_len) begin
        w = prog[idx];
        idx++;
        op = w[15:12];
        if (op >= 4'd1 && op <= 4'd3) begin
          a = ref_reg[w[7:4]];
          b = ref_reg[w[3:0]];
          if (op == 4'd1)      v = a + b;
          else if (op == 4'd2) v = a - b;
          else                 v = a * b;
          ref_reg[w[11:8]] = v;
          exp_q.push_back({w[11:8], v});
          edge_q.push_back(ecount);
          if (!first_seen) begin
            first_seen = 1'b1;
            first_lat  = (op == 4'd3) ? 6 : 4;
          end
        end
      end
      #1;
      if (bus.commit_valid !== 1'b0) begin
        if (exp_q.size() == 0) begin
          check($sformatf("%s_spurious_commit", name), 32'(bus.commit_valid), 32'd0);
        end else begin
          e  = exp_q.pop_front();
          ie = edge_q.pop_front();
          check($sformatf("%s_commit_valid", name), 32'(bus.commit_valid), 32'd1);
          check($sformatf("%s_commit_reg", name), 32'(bus.commit_reg), 32'(e[19:16]));
          check($sformatf("%s_commit_value", name), 32'(bus.commit_value), 32'(e[15:0]));
          if (!first_checked) begin
            first_checked = 1'b1;
            check($sformatf("%s_first_latency", name), 32'(ecount - ie), 32'(first_lat));
          end
        end
      end
    end
    check($sformatf("%s_all_issued", name), 32'(idx), 32'(prog_len));
    check($sformatf("%s_drained", name), 32'(exp_q.size()), 32'd0);
    if (expect_stall) check($sformatf("%s_stall_seen", name), 32'(saw), 32'd1);
    $display("program %s: %0d instructions, stall seen=%0d", name, prog_len, saw);
  endtask

  initial begin
    bus.pc        = 4'd15;
    bus.imem_we   = 1'b0;
    bus.imem_addr = 4'd0;
    bus.imem_data = 16'h0000;
    rst           = 1'b1;
    reset_model();
    @(negedge clk1);
    bus.imem_we   = 1'b1;
    bus.imem_addr = 4'd15;
    bus.imem_data = 16'h0000;
    @(negedge clk1);
    bus.imem_we = 1'b0;
    rst         = 1'b0;
    #1;
    check("reset_stall", 32'(bus.stall), 32'd0);
    check("reset_commit_valid", 32'(bus.commit_valid), 32'd0);
    check("reset_commit_reg", 32'(bus.commit_reg), 32'd0);
    check("reset_commit_value", 32'(bus.commit_value), 32'd0);

    for (int c = 0; c < 12; c++) begin
      @(negedge clk1);
      #1 check("idle_stall", 32'(bus.stall), 32'd0);
      @(posedge clk1);
      #1 check("idle_commit_valid", 32'(bus.commit_valid), 32'd0);
    end

    // Each register read back unchanged through r_k = r_k + r0.
    for (int k = 0; k < 15; k++) prog[k] = enc(1, k, k, 0);
    load_prog(15);
    run_prog("regbank_init", 1'b0);

    prog[0] = enc(1, 3, 1, 2);
    load_prog(1);
    run_prog("single_add", 1'b0);

    prog[0] = enc(1, 3, 1, 2);
    prog[1] = enc(3, 4, 3, 3);
    load_prog(2);
    run_prog("add_then_mul", 1'b0);

    for (int k = 0; k < 8; k++) prog[k] = enc((k % 2 == 0) ? 1 : 2, 8 + k, k, 7 - k);
    load_prog(8);
    run_prog("indep_adds", 1'b1);

    for (int k = 0; k < 9; k++) prog[k] = enc(3, 7 + k, k, k + 1);
    load_prog(9);
    run_prog("nine_muls", 1'b1);

    // Slow dependent MUL chain at the head while independent ADDs pile up behind it.
    for (int k = 0; k < 4; k++) prog[k] = enc(3, 1, 1, 1);
    for (int k = 0; k < 7; k++) prog[4 + k] = enc(1, 8 + k, 2 + k, 3);
    load_prog(11);
    run_prog("rob_fill", 1'b1);

    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 15; k++)
        prog[k] = enc($urandom_range(0, 5), $urandom_range(0, 15),
                      $urandom_range(0, 15), $urandom_range(0, 15));
      load_prog(15);
      run_prog($sformatf("random%0d", r), 1'b0);
    end

    // Reset while a MUL is executing: nothing of it may retire.
    prog[0] = enc(3, 4, 3, 3);
    load_prog(1);
    @(negedge clk1);
    bus.pc = 4'd0;
    @(negedge clk1);
    bus.pc = 4'd15;
    repeat (2) @(posedge clk1);
    #2 rst = 1'b1;
    #1;
    check("midreset_commit_valid", 32'(bus.commit_valid), 32'd0);
    check("midreset_commit_reg", 32'(bus.commit_reg), 32'd0);
    check("midreset_commit_value", 32'(bus.commit_value), 32'd0);
    check("midreset_stall", 32'(bus.stall), 32'd0);
    @(negedge clk1);
    @(negedge clk1);
    rst = 1'b0;
    reset_model();
    for (int c = 0; c < 10; c++) begin
      @(posedge clk1);
      #1 check("post_reset_no_commit", 32'(bus.commit_valid), 32'd0);
    end
    prog[0] = enc(1, 3, 1, 2);
    prog[1] = enc(1, 5, 4, 0);
    load_prog(2);
    run_prog("after_reset", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
